// File: rtl/dct_seq_pkg.sv
// Shared definitions for the DCT memory sequencer: FSM state encoding and
// default parameter values used by the top level and its delay line.
package dct_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } seq_state_e;

    localparam int DEF_ADDR_W  = 14;
    localparam int DEF_CA_W    = 4;
    localparam int DEF_RD_LAT  = 1;
    localparam int DEF_DCT_LAT = 16;

endpackage

// File: rtl/dct_valid_delay.sv
// Valid-token delay line: a read issued now surfaces DEPTH cycles later as a
// write strobe, matching memory read latency plus DCT pipeline latency.
module dct_valid_delay
    import dct_seq_pkg::*;
#(
    parameter int DEPTH = DEF_RD_LAT + DEF_DCT_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic vld_in,
    output logic vld_out
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = vld_in;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Clearing the line on reset guarantees an aborted run emits no more writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign vld_out = vld_q[DEPTH-1];

endmodule

// File: rtl/dct_mem_sequencer.sv
// Address/strobe sequencer that streams N blocks from the input memory through
// the DCT unit and writes the results, in order, to the output memory.
module dct_mem_sequencer
    import dct_seq_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int CA_W    = DEF_CA_W,
    parameter int RD_LAT  = DEF_RD_LAT,
    parameter int DCT_LAT = DEF_DCT_LAT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W-CA_W-1:0] num_blk,
    output logic                   busy,
    output logic                   done,
    output logic                   flag,
    output logic [ADDR_W-CA_W-1:0] RA_IN,
    output logic [CA_W-1:0]        CA_IN,
    output logic                   NCE_IN,
    output logic                   NWRT_IN,
    output logic [ADDR_W-CA_W-1:0] RA_OUT,
    output logic [CA_W-1:0]        CA_OUT,
    output logic                   NCE_OUT,
    output logic                   NWRT_OUT
);

    localparam int RA_W  = ADDR_W - CA_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam int DLY   = RD_LAT + DCT_LAT;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]  rd_rem_q, rd_rem_d;
    logic [CNT_W-1:0]  wr_rem_q, wr_rem_d;
    logic              flag_q, flag_d;
    logic [RA_W:0]     eff_blk;
    logic [CNT_W-1:0]  run_len;
    logic              rd_issue;
    logic              wr_vld;

    // A zero block count means the whole address space: one extra MSB holds 2^RA_W.
    always_comb begin
        eff_blk = (num_blk == '0) ? {1'b1, {RA_W{1'b0}}} : {1'b0, num_blk};
        run_len = {eff_blk, {CA_W{1'b0}}};
    end

    assign rd_issue = (state_q == ST_READ);

    dct_valid_delay #(
        .DEPTH (DLY)
    ) u_valid_delay (
        .clk     (clk),
        .reset   (reset),
        .vld_in  (rd_issue),
        .vld_out (wr_vld)
    );

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        rd_rem_d  = rd_rem_q;
        wr_rem_d  = wr_rem_q;
        flag_d    = flag_q;

        if (wr_vld) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            wr_rem_d  = wr_rem_q - CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_READ;
                    rd_addr_d = '0;
                    wr_addr_d = '0;
                    rd_rem_d  = run_len;
                    wr_rem_d  = run_len;
                end
            end
            ST_READ: begin
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                rd_rem_d  = rd_rem_q - CNT_W'(1);
                // The flip lands with the block's first word at the memory output.
                if (rd_addr_q[CA_W-1:0] == '0) begin
                    flag_d = ~flag_q;
                end
                if (rd_rem_q == CNT_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_vld && (wr_rem_q == CNT_W'(1))) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            rd_rem_q  <= '0;
            wr_rem_q  <= '0;
            flag_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            rd_rem_q  <= rd_rem_d;
            wr_rem_q  <= wr_rem_d;
            flag_q    <= flag_d;
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_FIN);
    assign flag            = flag_q;
    assign {RA_IN, CA_IN}  = rd_addr_q;
    assign NCE_IN          = ~rd_issue;
    assign NWRT_IN         = 1'b1;
    assign {RA_OUT, CA_OUT} = wr_addr_q;
    assign NCE_OUT         = ~wr_vld;
    assign NWRT_OUT        = ~wr_vld;

endmodule

// File: tb/tb_dct_mem_sequencer.sv
// Bench for dct_mem_sequencer: default instance plus a CA_W=3 / DCT_LAT=5 instance.
module tb_dct_mem_sequencer;

    localparam int AW = 14;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        start_a = 1'b0;
    logic [9:0]  nb_a = '0;
    logic        busy_a, done_a, flag_a, nce_in_a, nwrt_in_a, nce_out_a, nwrt_out_a;
    logic [9:0]  ra_in_a, ra_out_a;
    logic [3:0]  ca_in_a, ca_out_a;

    // overridden instance
    logic        start_b = 1'b0;
    logic [10:0] nb_b = '0;
    logic        busy_b, done_b, flag_b, nce_in_b, nwrt_in_b, nce_out_b, nwrt_out_b;
    logic [10:0] ra_in_b, ra_out_b;
    logic [2:0]  ca_in_b, ca_out_b;

    dct_mem_sequencer u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .num_blk(nb_a),
        .busy(busy_a), .done(done_a), .flag(flag_a),
        .RA_IN(ra_in_a), .CA_IN(ca_in_a), .NCE_IN(nce_in_a), .NWRT_IN(nwrt_in_a),
        .RA_OUT(ra_out_a), .CA_OUT(ca_out_a), .NCE_OUT(nce_out_a), .NWRT_OUT(nwrt_out_a)
    );

    dct_mem_sequencer #(.CA_W(3), .DCT_LAT(5)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .num_blk(nb_b),
        .busy(busy_b), .done(done_b), .flag(flag_b),
        .RA_IN(ra_in_b), .CA_IN(ca_in_b), .NCE_IN(nce_in_b), .NWRT_IN(nwrt_in_b),
        .RA_OUT(ra_out_b), .CA_OUT(ca_out_b), .NCE_OUT(nce_out_b), .NWRT_OUT(nwrt_out_b)
    );

    logic        sel = 1'b0;
    logic        m_busy, m_done, m_flag, m_nce_in, m_nwrt_in, m_nce_out, m_nwrt_out;
    logic [13:0] m_rd_addr, m_wr_addr;
    assign m_busy     = sel ? busy_b     : busy_a;
    assign m_done     = sel ? done_b     : done_a;
    assign m_flag     = sel ? flag_b     : flag_a;
    assign m_nce_in   = sel ? nce_in_b   : nce_in_a;
    assign m_nwrt_in  = sel ? nwrt_in_b  : nwrt_in_a;
    assign m_nce_out  = sel ? nce_out_b  : nce_out_a;
    assign m_nwrt_out = sel ? nwrt_out_b : nwrt_out_a;
    assign m_rd_addr  = sel ? {ra_in_b, ca_in_b}   : {ra_in_a, ca_in_a};
    assign m_wr_addr  = sel ? {ra_out_b, ca_out_b} : {ra_out_a, ca_out_a};

    int n_checks = 0;
    int n_pass = 0;
    logic flag_model_a = 1'b1;
    logic flag_model_b = 1'b1;

    // One run: reference is "read k at cycle k, write k at cycle D+k, addr k-1".
    task automatic run_seq(input bit s, input int nb, input int ca_w, input int d,
                           input bit noisy, input string tag);
        int l, nl, rd_n, wr_n, rd_first, wr_first, rd_err, wr_err;
        int done_n, done_cyc, busy_n, flag_err, misc_err, toggles, issued;
        logic fm, exp_flag, prev_flag;
        l  = 1 << ca_w;
        nl = ((nb == 0) ? (1 << (AW - ca_w)) : nb) * l;
        sel = s;
        fm = s ? flag_model_b : flag_model_a;
        rd_n = 0; wr_n = 0; rd_first = -1; wr_first = -1; rd_err = 0; wr_err = 0;
        done_n = 0; done_cyc = -1; busy_n = 0; flag_err = 0; misc_err = 0; toggles = 0;
        @(posedge clk); #1;
        if (s) begin start_b = 1'b1; nb_b = 11'(nb); end
        else   begin start_a = 1'b1; nb_a = 10'(nb); end
        prev_flag = m_flag;
        for (int c = 0; c <= nl + d + 6; c++) begin
            @(negedge clk);
            if (!m_nce_in) begin
                if (rd_n == 0) rd_first = c;
                if (m_rd_addr !== 14'(rd_n) || c != rd_first + rd_n) rd_err++;
                rd_n++;
            end
            if (!m_nce_out) begin
                if (wr_n == 0) wr_first = c;
                if (m_wr_addr !== 14'(wr_n) || c != wr_first + wr_n) wr_err++;
                wr_n++;
            end
            if (m_nwrt_in !== 1'b1 || m_nwrt_out !== m_nce_out) misc_err++;
            if (m_done) begin done_n++; done_cyc = c; end
            if (m_busy) busy_n++;
            issued = (c < 1) ? 0 : ((c - 1 < nl) ? c - 1 : nl);
            exp_flag = fm ^ ((((issued + l - 1) / l) % 2) != 0);
            if (m_flag !== exp_flag) flag_err++;
            if (m_flag !== prev_flag) toggles++;
            prev_flag = m_flag;
            @(posedge clk); #1;
            if (noisy && c < nl + d) begin
                if (s) begin start_b = 1'($urandom); nb_b = 11'($urandom); end
                else   begin start_a = 1'($urandom); nb_a = 10'($urandom); end
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
        end
        if (s) flag_model_b = fm ^ (((nl / l) % 2) != 0);
        else   flag_model_a = fm ^ (((nl / l) % 2) != 0);

        n_checks++; if (rd_n !== nl) $display("FAIL %s read_count got %0d want %0d", tag, rd_n, nl); else n_pass++;
        n_checks++; if (rd_first !== 1) $display("FAIL %s first_read_cycle got %0d want 1", tag, rd_first); else n_pass++;
        n_checks++; if (rd_err !== 0) $display("FAIL %s read_addr_seq errors got %0d want 0", tag, rd_err); else n_pass++;
        n_checks++; if (wr_n !== nl) $display("FAIL %s write_count got %0d want %0d", tag, wr_n, nl); else n_pass++;
        n_checks++; if (wr_first !== d + 1) $display("FAIL %s first_write_cycle got %0d want %0d", tag, wr_first, d + 1); else n_pass++;
        n_checks++; if (wr_err !== 0) $display("FAIL %s write_addr_seq errors got %0d want 0", tag, wr_err); else n_pass++;
        n_checks++; if (done_n !== 1) $display("FAIL %s done_pulses got %0d want 1", tag, done_n); else n_pass++;
        n_checks++; if (done_cyc !== nl + d + 1) $display("FAIL %s done_cycle got %0d want %0d", tag, done_cyc, nl + d + 1); else n_pass++;
        n_checks++; if (busy_n !== nl + d + 1) $display("FAIL %s busy_cycles got %0d want %0d", tag, busy_n, nl + d + 1); else n_pass++;
        n_checks++; if (flag_err !== 0) $display("FAIL %s flag_value errors got %0d want 0", tag, flag_err); else n_pass++;
        n_checks++; if (toggles !== nl / l) $display("FAIL %s flag_toggles got %0d want %0d", tag, toggles, nl / l); else n_pass++;
        n_checks++; if (misc_err !== 0) $display("FAIL %s nwrt_strobes errors got %0d want 0", tag, misc_err); else n_pass++;
    endtask

    task automatic check_idle_outputs(input bit s, input string tag);
        sel = s;
        #1;
        n_checks++;
        if ({m_busy, m_done, m_flag, m_nce_in, m_nce_out, m_nwrt_out} !== 6'b001111)
            $display("FAIL %s ctrl busy,done,flag,nce_in,nce_out,nwrt_out got %b want 001111", tag,
                     {m_busy, m_done, m_flag, m_nce_in, m_nce_out, m_nwrt_out});
        else n_pass++;
        n_checks++;
        if (m_rd_addr !== 14'd0 || m_wr_addr !== 14'd0)
            $display("FAIL %s addresses got rd=%0d wr=%0d want 0/0", tag, m_rd_addr, m_wr_addr);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs(1'b0, "reset_a");
        check_idle_outputs(1'b1, "reset_b");
        flag_model_a = 1'b1;
        flag_model_b = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_single_block();
        run_seq(1'b0, 1, 4, 17, 1'b0, "single_block");
    endtask

    task automatic test_three_blocks();
        run_seq(1'b0, 3, 4, 17, 1'b0, "three_blocks");
    endtask

    task automatic test_start_ignored();
        run_seq(1'b0, 2, 4, 17, 1'b1, "start_ignored");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_seq(1'b0, int'($urandom_range(1, 5)), 4, 17, 1'($urandom), "random_run");
        end
    endtask

    task automatic test_param_override();
        run_seq(1'b1, 2, 3, 6, 1'b0, "param_override");
    endtask

    task automatic test_full_wrap();
        run_seq(1'b0, 0, 4, 17, 1'b0, "full_wrap");
    endtask

    task automatic test_abort_in_drain();
        int wr_n, late_wr, late_done;
        wr_n = 0; late_wr = 0; late_done = 0;
        sel = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b1; nb_a = 10'd1;
        for (int c = 0; c <= 24; c++) begin
            @(negedge clk);
            if (!nce_out_a) wr_n++;
            @(posedge clk); #1;
            start_a = 1'b0;
            if (c == 23) reset = 1'b0;
        end
        @(negedge clk);
        check_idle_outputs(1'b0, "abort_reset_state");
        flag_model_a = 1'b1;
        n_checks++;
        if (wr_n !== 7) $display("FAIL abort_writes_before_reset got %0d want 7", wr_n); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!nwrt_out_a || !nce_out_a) late_wr++;
            if (done_a || busy_a) late_done++;
        end
        n_checks++;
        if (late_wr !== 0) $display("FAIL abort_late_writes got %0d want 0", late_wr); else n_pass++;
        n_checks++;
        if (late_done !== 0) $display("FAIL abort_late_done_busy got %0d want 0", late_done); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_three_blocks();
        test_start_ignored();
        test_back_to_back();
        test_param_override();
        test_full_wrap();
        test_abort_in_drain();
        test_single_block();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout reached got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dct_mem_sequencer.md
DCT_MEM_SEQUENCER -- requirements
Module: dct_mem_sequencer

Interface
REQ-001 Parameter ADDR_W, default 14, SHALL set the total memory address width (RA width + CA width).
REQ-002 Parameter CA_W, default 4, SHALL set the column-address width; block length L = 2^CA_W samples.
REQ-003 Parameter RD_LAT, default 1, SHALL give the input-memory read latency in cycles.
REQ-004 Parameter DCT_LAT, default 16, SHALL give the DCT pipeline latency in cycles, input sample to output sample.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be the synchronous, active-low reset.
REQ-007 start  input  1  SHALL request a run when high in IDLE.
REQ-008 num_blk  input  ADDR_W-CA_W  SHALL give the block count, sampled on accepted start; 0 means 2^(ADDR_W-CA_W) blocks.
REQ-009 busy  output  1  SHALL be high from the cycle after an accepted start until done.
REQ-010 done  output  1  SHALL pulse high for exactly one cycle at run completion.
REQ-011 flag  output  1  SHALL be the block-parity strobe to the DCT unit.
REQ-012 RA_IN/CA_IN  output  ADDR_W-CA_W / CA_W  SHALL be the input-memory row/column address.
REQ-013 NCE_IN, NWRT_IN  output  1 each  SHALL be the active-low input-memory chip enable and write enable; NWRT_IN SHALL be constant 1.
REQ-014 RA_OUT/CA_OUT  output  ADDR_W-CA_W / CA_W  SHALL be the output-memory row/column address.
REQ-015 NCE_OUT, NWRT_OUT  output  1 each  SHALL be the active-low output-memory chip enable and write enable, always equal to each other.

Function
REQ-016 FSM states SHALL be IDLE, READ, DRAIN, FIN; reset state IDLE.
REQ-017 IDLE->READ on start=1; start in any other state SHALL be ignored.
REQ-018 In READ, NCE_IN SHALL be 0 and the read address {RA_IN,CA_IN} SHALL start at 0 and increment by 1 each cycle.
REQ-019 After N*L reads (N = effective block count), READ->DRAIN; NCE_IN SHALL return to 1 the next cycle.
REQ-020 The read address SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-021 Each issued read SHALL launch a valid token into a delay line of RD_LAT+DCT_LAT stages; a token emerging SHALL assert NCE_OUT=NWRT_OUT=0 for that cycle.
REQ-022 The write address SHALL start at 0 per run and increment by 1 after each write, wrapping like REQ-020.
REQ-023 First write SHALL occur exactly RD_LAT+DCT_LAT cycles after the first read; writes SHALL be contiguous, N*L in total.
REQ-024 DRAIN->FIN when the last token has been written; FIN SHALL assert done for one cycle and return to IDLE.
REQ-025 flag SHALL invert on every clock edge at which a read with CA_IN=0 is issued, so its new value appears with that block's first word at the memory output (RD_LAT=1).
REQ-026 flag SHALL hold its value in IDLE, DRAIN and FIN and SHALL persist across runs (not reset by start).
REQ-027 Outside READ, NCE_IN SHALL be 1; outside valid-token cycles, NCE_OUT and NWRT_OUT SHALL be 1.
REQ-028 Counters SHALL be sized to hold N*L = 2^ADDR_W without overflow.

Reset
REQ-029 On reset=0 at a clock edge: state IDLE, busy=0, done=0, flag=1, all addresses 0, NCE_IN=NCE_OUT=NWRT_OUT=1, delay line cleared.
REQ-030 Reset mid-run SHALL abort the run with no further writes and no done pulse.

Structure
REQ-031 State encoding and the default parameter values SHALL live in shared package dct_seq_pkg.
REQ-032 The valid-token delay line SHALL be sub-module dct_valid_delay, parameterised by depth.
REQ-033 The block SHALL contain no memory or DCT instances; it drives their ports only.

Verification
REQ-034 Reset then start, num_blk=1 -> reads at addresses 0..15 on cycles 1..16, flag 1->0 after first read, writes 0..15 starting 17 cycles after the first read, done once.
REQ-035 num_blk=3 -> 48 contiguous reads, flag toggles 3 times (0,1,0), 48 writes, busy high for 48+17 cycles plus FIN.
REQ-036 num_blk=0 -> 16384 reads, address wraps 16383->0 only at end, 16384 writes, done once.
REQ-037 start pulsed repeatedly during READ/DRAIN -> no restart, counts unchanged, single done.
REQ-038 reset=0 during cycle 8 of DRAIN -> no further NWRT_OUT=0, no done, all outputs at reset values next cycle.
REQ-039 Parameter override CA_W=3, DCT_LAT=5, num_blk=2 -> 16 reads, flag toggles every 8 reads, first write 6 cycles after first read.
